// File: rtl/counter_pkg.sv
// Shared types for the parametrised up/down counter: end-of-range modes and
// the two-state run/done machine.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2,
        CNT_RSVD    = 2'd3
    } cnt_mode_e;

    typedef enum logic {
        CNT_RUN  = 1'b0,
        CNT_DONE = 1'b1
    } cnt_state_e;

    // The reserved encoding is treated exactly like WRAP.
    function automatic logic mode_wraps(input cnt_mode_e m);
        return (m == CNT_WRAP) || (m == CNT_RSVD);
    endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational single-step of the counter: next value and boundary detect.
// Compare-before-step keeps every value inside WIDTH bits.
module counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_up,
    input  cnt_mode_e        i_mode,
    output logic [WIDTH-1:0] o_next_count,
    output logic             o_at_boundary
);

    always_comb begin
        o_at_boundary = i_up ? (i_count == i_limit) : (i_count == '0);
        o_next_count  = i_count;
        if (!o_at_boundary) begin
            o_next_count = i_up ? (i_count + 1'b1) : (i_count - 1'b1);
        end else if (mode_wraps(i_mode)) begin
            o_next_count = i_up ? '0 : i_limit;
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Loadable up/down counter with runtime limit, wrap/saturate/one-shot end
// behaviour, registered terminal-count pulse and sticky overflow flag.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_sat_hold;
    cnt_state_e       r_state;

    cnt_mode_e        w_mode;
    logic [WIDTH-1:0] w_step_count;
    logic             w_at_boundary;
    logic [WIDTH-1:0] w_load_val;
    logic             w_active;
    logic             w_clamp;
    logic             w_bnd;
    logic             w_tc_set;

    assign w_mode = cnt_mode_e'(mode);

    counter_step #(.WIDTH(WIDTH)) u_step (
        .i_count       (r_count),
        .i_limit       (limit),
        .i_up          (up),
        .i_mode        (w_mode),
        .o_next_count  (w_step_count),
        .o_at_boundary (w_at_boundary)
    );

    // r_sat_hold remembers that the saturating boundary already pulsed, so
    // only the first attempt at the rail produces tc.
    always_comb begin
        w_load_val = (load_data > limit) ? limit : load_data;
        w_active   = en && !load && (r_state == CNT_RUN);
        w_clamp    = w_active && (r_count > limit);
        w_bnd      = w_active && !w_clamp && w_at_boundary;
        w_tc_set   = w_bnd && !((w_mode == CNT_SAT) && r_sat_hold);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count    <= RESET_VAL;
            r_tc       <= 1'b0;
            r_ovf      <= 1'b0;
            r_sat_hold <= 1'b0;
            r_state    <= CNT_RUN;
        end else begin
            r_tc  <= w_tc_set;
            r_ovf <= w_tc_set || (r_ovf && !clr_ovf);
            case (r_state)
                CNT_RUN: begin
                    if (load) begin
                        r_count    <= w_load_val;
                        r_sat_hold <= 1'b0;
                    end else if (w_clamp) begin
                        r_count    <= limit;
                        r_sat_hold <= 1'b0;
                    end else if (w_active) begin
                        r_count    <= w_step_count;
                        r_sat_hold <= w_at_boundary && (w_mode == CNT_SAT);
                        if (w_at_boundary && (w_mode == CNT_ONESHOT)) begin
                            r_state <= CNT_DONE;
                        end
                    end
                end
                CNT_DONE: begin
                    // Frozen until a load; en and mode changes are ignored.
                    if (load) begin
                        r_count    <= w_load_val;
                        r_sat_hold <= 1'b0;
                        r_state    <= CNT_RUN;
                    end
                end
                default: r_state <= CNT_RUN;
            endcase
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;
    assign done  = (r_state == CNT_DONE);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed scoreboard bench for updown_counter_param (WIDTH=4, RESET_VAL=0).
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset_n, en, up, load, clr_ovf;
    logic [1:0] mode;
    logic [3:0] limit, load_data;
    logic [3:0] count;
    logic       tc, ovf, done;

    int n_run  = 0;
    int n_fail = 0;
    int n_push = 0;

    logic [6:0] exp_q[$];
    logic [6:0] m_exp, m_got;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .RESET_VAL(4'd0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .up        (up),
        .mode      (mode),
        .limit     (limit),
        .load      (load),
        .load_data (load_data),
        .clr_ovf   (clr_ovf),
        .count     (count),
        .tc        (tc),
        .ovf       (ovf),
        .done      (done)
    );

    // Monitor: every edge produces an output word; compare it with the head of the queue.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_got = {count, tc, ovf, done};
            n_run++;
            if (m_got !== m_exp) begin
                n_fail++;
                $display("FAIL vec%0d {count,tc,ovf,done}: got %h/%b/%b/%b want %h/%b/%b/%b",
                         n_run, m_got[6:3], m_got[2], m_got[1], m_got[0],
                         m_exp[6:3], m_exp[2], m_exp[1], m_exp[0]);
            end
        end
    end

    task automatic set_in(input logic r, input logic l, input logic [3:0] d,
                          input logic e, input logic u, input logic [1:0] m,
                          input logic [3:0] lm, input logic c);
        reset_n = r; load = l; load_data = d; en = e; up = u;
        mode = m; limit = lm; clr_ovf = c;
    endtask

    task automatic tick(input logic [3:0] c, input logic t, input logic o, input logic d);
        exp_q.push_back({c, t, o, d});
        n_push++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 15, 0);
        @(negedge clk);

        // reset, load 3, count up through wrap
        set_in(0, 0, 0, 0, 0, 0, 15, 0); tick(0, 0, 0, 0);
        set_in(1, 1, 3, 1, 1, 0, 15, 0); tick(3, 0, 0, 0);
        set_in(1, 0, 0, 1, 1, 0, 15, 0);
        for (int v = 4; v <= 15; v++) tick(4'(v), 0, 0, 0);
        tick(0, 1, 1, 0);
        tick(1, 0, 1, 0);

        // down wrap, clr_ovf coinciding with a new tc
        set_in(1, 1, 1, 1, 0, 0, 9, 0); tick(1, 0, 1, 0);
        set_in(1, 0, 0, 1, 0, 0, 9, 0); tick(0, 0, 1, 0);
        set_in(1, 0, 0, 1, 0, 0, 9, 1); tick(9, 1, 1, 0);
        tick(8, 0, 0, 0);

        // saturate
        set_in(1, 1, 4, 1, 1, 1, 5, 0); tick(4, 0, 0, 0);
        set_in(1, 0, 0, 1, 1, 1, 5, 0);
        tick(5, 0, 0, 0);
        tick(5, 1, 1, 0);
        repeat (4) tick(5, 0, 1, 0);
        set_in(1, 0, 0, 1, 0, 1, 5, 0); tick(4, 0, 1, 0);
        set_in(1, 0, 0, 1, 1, 1, 5, 0);
        tick(5, 0, 1, 0);
        tick(5, 1, 1, 0);
        tick(5, 0, 1, 0);

        // one-shot
        set_in(1, 1, 0, 1, 1, 2, 7, 0); tick(0, 0, 1, 0);
        set_in(1, 0, 0, 1, 1, 2, 7, 0);
        for (int v = 1; v <= 7; v++) tick(4'(v), 0, 1, 0);
        tick(7, 1, 1, 1);
        tick(7, 0, 1, 1);
        set_in(1, 0, 0, 1, 1, 0, 7, 0); tick(7, 0, 1, 1);
        set_in(1, 1, 2, 1, 1, 2, 7, 0); tick(2, 0, 1, 0);
        set_in(1, 0, 0, 1, 1, 2, 7, 0);
        tick(3, 0, 1, 0);
        tick(4, 0, 1, 0);

        // clamp and limit==0
        set_in(1, 1, 12, 1, 1, 0, 15, 0); tick(12, 0, 1, 0);
        set_in(1, 0, 0, 1, 1, 0, 6, 0);   tick(6, 0, 1, 0);
        set_in(1, 1, 14, 1, 1, 0, 6, 1);  tick(6, 0, 0, 0);
        set_in(1, 0, 0, 1, 1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 1, 0);
        tick(0, 1, 1, 0);
        set_in(1, 0, 0, 0, 1, 0, 0, 0);   tick(0, 0, 1, 0);

        // reserved mode wraps
        set_in(1, 1, 2, 1, 1, 3, 2, 1); tick(2, 0, 0, 0);
        set_in(1, 0, 0, 1, 1, 3, 2, 0); tick(0, 1, 1, 0);

        // reset while in DONE with load and en active
        set_in(1, 1, 9, 1, 1, 2, 9, 0); tick(9, 0, 1, 0);
        set_in(1, 0, 0, 1, 1, 2, 9, 0); tick(9, 1, 1, 1);
        set_in(0, 1, 5, 1, 1, 2, 9, 0); tick(0, 0, 0, 0);
        set_in(1, 0, 0, 1, 1, 0, 15, 0);
        tick(1, 0, 0, 0);
        tick(2, 0, 0, 0);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0 || n_run != n_push) begin
            n_fail++;
            $display("FAIL drain: checked %0d want %0d", n_run, n_push);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised next-generation loadable counter: width set by parameter, runtime terminal limit, up/down direction, three end-of-range modes (wrap, saturate, one-shot).
- Terminal-count pulse and sticky overflow flag added.
- General-purpose timing/sequencing counter for the lab designs; a drop-in superset of the 4-bit loadable counter (WIDTH=4, limit=15, mode=WRAP, up, en=1).

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- RESET_VAL, 0, count value after reset (must be <= 2**WIDTH-1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- mode  input  2  end-of-range mode: 0 WRAP, 1 SATURATE, 2 ONESHOT, 3 reserved (behaves as WRAP).
- limit  input  WIDTH  upper bound of the count range, 0..limit inclusive.
- load  input  1  synchronous parallel load.
- load_data  input  WIDTH  value to load.
- clr_ovf  input  1  clears the sticky overflow flag.
- count  output  WIDTH  registered count value.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky flag, set on every tc.
- done  output  1  ONESHOT finished; counter frozen.

Behaviour:
- Reset: one clock, single clock domain; reset is synchronous and active-low (reset_n sampled on the rising edge of clk). On reset: count=RESET_VAL, tc=0, ovf=0, done=0, state=RUN. Reset overrides all other inputs, including mid-count and in DONE.
- Priority per cycle: reset_n low > load > en > hold.
- Load: count <= min(load_data, limit). Also clears done and returns state to RUN. tc=0 that cycle. Load with en=1 loads only; no step that cycle.
- Step, en=1 in RUN, up=1, count<limit: count+1.
- Step, en=1 in RUN, up=0, count>0: count-1.
- Boundary, up=1, count==limit (or down, count==0), by mode:
  - WRAP: count <= 0 (up) or limit (down); tc=1 next cycle.
  - SATURATE: count holds; tc=1 only on the first cycle the boundary step is attempted; repeated attempts do not re-pulse until count leaves the boundary.
  - ONESHOT: count holds; tc=1; state -> DONE, done=1. In DONE, en is ignored until load or reset.
- Limit changed below count: if count>limit on an enabled cycle, count <= limit and tc=0. Out-of-range is corrected without a pulse.
- limit==0: count stays 0. Every enabled cycle is a boundary: WRAP pulses tc every enabled cycle.
- tc latency: registered, high in the same cycle the post-boundary count is visible, width exactly one clock per event.
- ovf: set when tc is set. clr_ovf clears it. Simultaneous set and clear: set wins.
- Mode change mid-count takes effect on the next step. Changing mode while in DONE does not leave DONE.
- Width rules: all arithmetic in WIDTH bits. No intermediate value exceeds 2**WIDTH-1 (compare before increment; no carry-out used).
- States: RUN, DONE (2-state FSM). RUN->DONE only on a ONESHOT boundary step. DONE->RUN only on load or reset.

Decomposition:
- Shared package counter_pkg:
  - typedef enum logic [1:0] cnt_mode_e {CNT_WRAP, CNT_SAT, CNT_ONESHOT, CNT_RSVD}.
  - typedef enum logic cnt_state_e {CNT_RUN, CNT_DONE}.
- One combinational sub-module, counter_step: inputs count, limit, up, mode; outputs next_count and at_boundary. It is unit-testable in isolation.
- The top level holds the registers, the FSM, the tc edge logic and ovf.

Test Plan (WIDTH=4):
- Reset/load: reset_n low 1 cycle -> count=0, flags 0. Then load=1, load_data=3, limit=15 -> count=3 next cycle. Release load, en=1, up=1 -> 4,5,...,15,0 with tc=1 exactly on the cycle count=0; ovf=1 thereafter.
- Down WRAP: limit=9, load 1, up=0 -> 0, then 9 with tc pulse. clr_ovf=1 on the same cycle as a new tc -> ovf stays 1.
- SATURATE: limit=5, load 4, up=1 held 6 cycles -> 5,5,5,... with a single tc pulse. up=0 for 1 cycle, then up=1 -> 4, 5, and tc pulses again.
- ONESHOT: limit=7, load 0, up=1 -> reaches 7, tc=1, done=1, count frozen at 7 despite en. load 2 -> done=0, counting resumes 3,4,...
- Clamp: count=12, limit changed to 6 with en=1 -> count=6, tc=0. load_data=14 with limit=6 -> count=6. limit=0 in WRAP -> count 0 and tc every enabled cycle.
- Reset mid-operation: reset_n low while en=1, load=1, count=9, in DONE -> next cycle count=RESET_VAL, done=0, ovf=0, tc=0. Counting resumes from RESET_VAL the cycle after reset_n returns high.
